// File: rtl/ctrl_pkg.sv
// Shared decode definitions for the ID-stage control unit.
// Holds the opcode/funct encodings, the ALU operation codes, the packed
// control bundle carried into ID/EX, and the all-zero bubble value.
package ctrl_pkg;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // R-type funct codes (instruction[5:0])
  localparam logic [5:0] FN_ADD = 6'b000000;
  localparam logic [5:0] FN_SUB = 6'b000001;
  localparam logic [5:0] FN_MUL = 6'b000010;

  // ALU operation selects
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder.
// Ports:
//   opcode_i  - instruction[31:26]
//   funct_i   - instruction[5:0]
//   ctrl_o    - decoded control bundle (all zero for illegal encodings)
//   rt_used_o - instruction reads rt as a source
//   is_mul_o  - instruction is an R-type MUL
//   illegal_o - unknown opcode, or R-type with unknown funct
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output ctrl_t      ctrl_o,
  output logic       rt_used_o,
  output logic       is_mul_o,
  output logic       illegal_o
);

  always_comb begin
    ctrl_o    = CTRL_BUBBLE;
    rt_used_o = 1'b0;
    is_mul_o  = 1'b0;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        rt_used_o = 1'b1;
        case (funct_i)
          FN_ADD, FN_SUB, FN_MUL: begin
            ctrl_o.reg_dst   = 1'b1;
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_op    = ALU_OP_FUNCT;
            is_mul_o         = (funct_i == FN_MUL);
          end
          default: illegal_o = 1'b1;
        endcase
      end
      OP_LW: begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.alu_op     = ALU_OP_ADD;
      end
      OP_SW: begin
        rt_used_o        = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_op    = ALU_OP_ADD;
      end
      OP_BEQ: begin
        rt_used_o     = 1'b1;
        ctrl_o.branch = 1'b1;
        ctrl_o.alu_op = ALU_OP_SUB;
      end
      OP_ADDI: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALU_OP_ADD;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipelined_ctrl_unit.sv
// Decode-stage control unit with ID/EX pipeline register.
// Decodes the IF/ID instruction, inserts bubbles for load-use hazards, branch
// flushes and multi-cycle MUL occupancy, and drives the fetch stall line.
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-high reset
//   id_valid            - IF/ID holds a real instruction
//   id_opcode, id_funct - instruction opcode and funct fields
//   id_rs, id_rt, id_rd - register specifiers from IF/ID
//   flush               - branch taken in EX; kill the instruction in ID
//   stall               - combinational; hold PC and IF/ID this cycle
//   illegal             - registered one-cycle pulse on a consumed illegal instruction
//   ex_*                - registered ID/EX control bundle and specifiers
module pipelined_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned ALU_OP_W    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [5:0]            id_opcode,
  input  logic [5:0]            id_funct,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  flush,
  output logic                  stall,
  output logic                  illegal,
  output logic                  ex_valid,
  output logic                  ex_reg_dst,
  output logic                  ex_branch,
  output logic                  ex_mem_read,
  output logic                  ex_mem_to_reg,
  output logic                  ex_mem_write,
  output logic                  ex_alu_src,
  output logic                  ex_reg_write,
  output logic [ALU_OP_W-1:0]   ex_alu_op,
  output logic [5:0]            ex_funct,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_dest
);

  localparam int unsigned CntW = (MUL_LATENCY > 0) ? $clog2(MUL_LATENCY + 1) : 1;

  typedef enum logic {StIdle, StBusy} state_e;

  ctrl_t dec_ctrl;
  logic  dec_rt_used;
  logic  dec_is_mul;
  logic  dec_illegal;

  ctrl_decode u_decode (
    .opcode_i  (id_opcode),
    .funct_i   (id_funct),
    .ctrl_o    (dec_ctrl),
    .rt_used_o (dec_rt_used),
    .is_mul_o  (dec_is_mul),
    .illegal_o (dec_illegal)
  );

  // ID/EX register
  ctrl_t                 ctrl_q;
  logic                  ex_valid_q;
  logic                  illegal_q;
  logic [5:0]            funct_q;
  logic [REG_ADDR_W-1:0] rs_q;
  logic [REG_ADDR_W-1:0] rt_q;
  logic [REG_ADDR_W-1:0] dest_q;

  state_e         state_q;
  logic [CntW-1:0] cnt_q;

  logic lu;
  logic busy;
  logic issue;

  // A load into $zero never produces a value worth waiting for.
  assign lu = ex_valid_q & ctrl_q.mem_read & (rt_q != '0) & id_valid &
              ((rt_q == id_rs) | (dec_rt_used & (rt_q == id_rt)));

  assign busy  = (state_q == StBusy);
  assign stall = lu | busy;

  // Everything that is not a clean issue turns into a bubble.
  assign issue = ~flush & ~stall & id_valid & ~dec_illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q     <= CTRL_BUBBLE;
      ex_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      funct_q    <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      dest_q     <= '0;
    end else begin
      // Pulse only when the illegal instruction actually leaves ID.
      illegal_q <= id_valid & ~flush & ~stall & dec_illegal;
      if (issue) begin
        ctrl_q     <= dec_ctrl;
        ex_valid_q <= 1'b1;
        funct_q    <= id_funct;
        rs_q       <= id_rs;
        rt_q       <= id_rt;
        dest_q     <= dec_ctrl.reg_dst ? id_rd : id_rt;
      end else begin
        ctrl_q     <= CTRL_BUBBLE;
        ex_valid_q <= 1'b0;
        funct_q    <= '0;
        rs_q       <= '0;
        rt_q       <= '0;
        dest_q     <= '0;
      end
    end
  end

  // MUL occupancy: counter holds the remaining busy cycles including this one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else if (flush) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (issue && dec_is_mul && (MUL_LATENCY > 0)) begin
            state_q <= StBusy;
            cnt_q   <= CntW'(MUL_LATENCY);
          end
        end
        StBusy: begin
          if (cnt_q == CntW'(1)) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign illegal       = illegal_q;
  assign ex_valid      = ex_valid_q;
  assign ex_reg_dst    = ctrl_q.reg_dst;
  assign ex_branch     = ctrl_q.branch;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_alu_op     = ALU_OP_W'(ctrl_q.alu_op);
  assign ex_funct      = funct_q;
  assign ex_rs         = rs_q;
  assign ex_rt         = rt_q;
  assign ex_dest       = dest_q;

endmodule

// File: tb/tb_pipelined_ctrl_unit.sv
module tb_pipelined_ctrl_unit;

  localparam int unsigned LAT = 3;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, RT = 6'b000000;

  logic       clk, reset, flush;
  logic       id_valid;
  logic [5:0] id_opcode, id_funct;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       stall, illegal, ex_valid;
  logic       ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write;
  logic       ex_alu_src, ex_reg_write;
  logic [1:0] ex_alu_op;
  logic [5:0] ex_funct;
  logic [4:0] ex_rs, ex_rt, ex_dest;

  // Second instance with single-cycle MUL, fed from its own inputs.
  logic       b_valid, b_flush;
  logic [5:0] b_opcode, b_funct;
  logic [4:0] b_rs, b_rt, b_rd;
  logic       b_stall, b_illegal, b_ex_valid;
  logic       b_reg_dst, b_branch, b_mem_read, b_mem_to_reg, b_mem_write;
  logic       b_alu_src, b_reg_write;
  logic [1:0] b_alu_op;
  logic [5:0] b_ex_funct;
  logic [4:0] b_ex_rs, b_ex_rt, b_ex_dest;

  int total = 0;
  int bad = 0;
  int ill_cnt = 0;
  bit chk_en = 0;

  pipelined_ctrl_unit #(.REG_ADDR_W(5), .MUL_LATENCY(LAT), .ALU_OP_W(2)) u_dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
    .stall(stall), .illegal(illegal), .ex_valid(ex_valid), .ex_reg_dst(ex_reg_dst),
    .ex_branch(ex_branch), .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
    .ex_alu_op(ex_alu_op), .ex_funct(ex_funct), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_dest(ex_dest)
  );

  pipelined_ctrl_unit #(.REG_ADDR_W(5), .MUL_LATENCY(0), .ALU_OP_W(2)) u_dut0 (
    .clk(clk), .reset(reset), .id_valid(b_valid), .id_opcode(b_opcode),
    .id_funct(b_funct), .id_rs(b_rs), .id_rt(b_rt), .id_rd(b_rd), .flush(b_flush),
    .stall(b_stall), .illegal(b_illegal), .ex_valid(b_ex_valid), .ex_reg_dst(b_reg_dst),
    .ex_branch(b_branch), .ex_mem_read(b_mem_read), .ex_mem_to_reg(b_mem_to_reg),
    .ex_mem_write(b_mem_write), .ex_alu_src(b_alu_src), .ex_reg_write(b_reg_write),
    .ex_alu_op(b_alu_op), .ex_funct(b_ex_funct), .ex_rs(b_ex_rs), .ex_rt(b_ex_rt),
    .ex_dest(b_ex_dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    bit       v;
    bit       reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
    bit [1:0] alu_op;
    bit [5:0] funct;
    bit [4:0] rs, rt, dest;
  } ex_t;

  ex_t m;
  bit  m_ill;
  int  m_busy;  // cycles of MUL occupancy still to come

  function automatic void ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                     output ex_t e, output bit legal,
                                     output bit reads_rt, output bit mul);
    e = '0; legal = 1; reads_rt = 0; mul = 0;
    case (op)
      6'b000000: begin
        reads_rt = 1;
        if (fn == 6'd0 || fn == 6'd1 || fn == 6'd2) begin
          e.reg_dst = 1; e.reg_write = 1; e.alu_op = 2'b10; mul = (fn == 6'd2);
        end else legal = 0;
      end
      6'b100011: begin e.alu_src = 1; e.mem_read = 1; e.mem_to_reg = 1; e.reg_write = 1; end
      6'b101011: begin reads_rt = 1; e.alu_src = 1; e.mem_write = 1; end
      6'b000100: begin reads_rt = 1; e.branch = 1; e.alu_op = 2'b01; end
      6'b001000: begin e.alu_src = 1; e.reg_write = 1; end
      default:   legal = 0;
    endcase
  endfunction

  function automatic bit model_stall();
    ex_t e; bit legal, reads_rt, mul, lu;
    ref_decode(id_opcode, id_funct, e, legal, reads_rt, mul);
    lu = m.v && m.mem_read && (m.rt != 0) && id_valid &&
         ((m.rt == id_rs) || (reads_rt && (m.rt == id_rt)));
    return lu || (m_busy > 0);
  endfunction

  always @(posedge clk or posedge reset) begin : model
    ex_t e; bit legal, reads_rt, mul, hz;
    if (reset) begin
      m <= '0; m_ill <= 0; m_busy <= 0;
    end else begin
      ref_decode(id_opcode, id_funct, e, legal, reads_rt, mul);
      hz = model_stall();
      m_ill <= id_valid && !flush && !hz && !legal;
      if (flush) begin
        m <= '0; m_busy <= 0;
      end else if (hz) begin
        m <= '0;
        if (m_busy > 0) m_busy <= m_busy - 1;
      end else if (!id_valid || !legal) begin
        m <= '0;
      end else begin
        e.v = 1; e.funct = id_funct; e.rs = id_rs; e.rt = id_rt;
        e.dest = e.reg_dst ? id_rd : id_rt;
        m <= e;
        if (mul) m_busy <= LAT;
      end
    end
  end

  always @(negedge clk) begin
    if (illegal === 1'b1) ill_cnt++;
    if (!reset && chk_en) begin
      chk("cmp_stall", stall, model_stall());
      chk("cmp_illegal", illegal, m_ill);
      chk("cmp_valid", ex_valid, m.v);
      chk("cmp_ctrl", {ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write,
                       ex_alu_src, ex_reg_write, ex_alu_op},
          {m.reg_dst, m.branch, m.mem_read, m.mem_to_reg, m.mem_write,
           m.alu_src, m.reg_write, m.alu_op});
      chk("cmp_funct", ex_funct, m.funct);
      chk("cmp_spec", {ex_rs, ex_rt, ex_dest}, {m.rs, m.rt, m.dest});
    end
  end

  // ---------------- stimulus ----------------
  // Present one instruction until it is consumed; report stall cycles seen.
  task automatic send(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, output int stalls);
    bit done = 0;
    id_valid = 1; id_opcode = op; id_funct = fn; id_rs = rs; id_rt = rt; id_rd = rd;
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stall !== 1'b1) begin done = 1; break; end
      stalls++;
    end
    if (!done) chk("send_timeout", 1, 0);
    @(posedge clk); #1;
    id_valid = 0; id_opcode = 0; id_funct = 0; id_rs = 0; id_rt = 0; id_rd = 0;
  endtask

  initial begin
    int s, c0;
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, c0;
    reset = 1; flush = 0;
    id_valid = 0; id_opcode = 0; id_funct = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    b_valid = 0; b_flush = 0; b_opcode = 0; b_funct = 0; b_rs = 0; b_rt = 0; b_rd = 0;
    #1;
    chk("reset_outputs", {illegal, ex_valid, ex_reg_write, ex_mem_read, ex_alu_op, ex_dest}, 0);
    chk("reset_stall", stall, 0);
    repeat (2) @(posedge clk);
    #2 reset = 0;
    chk_en = 1;

    // Load-use: LW r5 then ADD r7 = r5 + r2
    send(LW, 6'd0, 5'd1, 5'd5, 5'd0, s);
    chk("lw_issue_stall", s, 0);
    send(RT, 6'd0, 5'd5, 5'd2, 5'd7, s);
    chk("lu_stall_cycles", s, 1);
    chk("add_valid", ex_valid, 1);
    chk("add_dest", ex_dest, 7);
    chk("add_alu_op", ex_alu_op, 2'b10);

    // $zero load never hazards
    send(LW, 6'd0, 5'd3, 5'd0, 5'd0, s);
    send(RT, 6'd0, 5'd0, 5'd0, 5'd4, s);
    chk("zero_no_stall", s, 0);
    chk("zero_valid", ex_valid, 1);

    // rt-used rules
    send(LW, 6'd0, 5'd1, 5'd9, 5'd0, s);
    send(SW, 6'd0, 5'd1, 5'd9, 5'd0, s);
    chk("sw_rt_stall", s, 1);
    send(LW, 6'd0, 5'd1, 5'd9, 5'd0, s);
    send(ADDI, 6'd0, 5'd2, 5'd9, 5'd0, s);
    chk("addi_rt_nostall", s, 0);
    send(LW, 6'd0, 5'd1, 5'd9, 5'd0, s);
    send(BEQ, 6'd0, 5'd3, 5'd9, 5'd0, s);
    chk("beq_rt_stall", s, 1);
    chk("beq_alu_op", ex_alu_op, 2'b01);

    // MUL occupancy
    send(RT, 6'd2, 5'd1, 5'd2, 5'd3, s);
    chk("mul_issue_stall", s, 0);
    chk("mul_funct", ex_funct, 6'd2);
    send(ADDI, 6'd0, 5'd3, 5'd4, 5'd0, s);
    chk("mul_stall_cycles", s, 3);

    // Single-cycle MUL instance: follower issues immediately
    b_valid = 1; b_opcode = RT; b_funct = 6'd2; b_rs = 1; b_rt = 2; b_rd = 3;
    @(negedge clk); chk("m0_stall_a", b_stall, 0);
    @(posedge clk); #1;
    chk("m0_mul_valid", b_ex_valid, 1);
    chk("m0_mul_funct", b_ex_funct, 6'd2);
    b_opcode = ADDI; b_funct = 0; b_rs = 3; b_rt = 4; b_rd = 0;
    @(negedge clk); chk("m0_stall_b", b_stall, 0);
    @(posedge clk); #1;
    b_valid = 0;
    chk("m0_addi_valid", b_ex_valid, 1);
    chk("m0_addi_dest", b_ex_dest, 4);

    // Flush on the second busy cycle
    send(RT, 6'd2, 5'd1, 5'd2, 5'd3, s);
    id_valid = 1; id_opcode = RT; id_funct = 0; id_rs = 7; id_rt = 8; id_rd = 9;
    @(negedge clk); chk("busy1_stall", stall, 1);
    @(posedge clk); #1 flush = 1;
    @(negedge clk); chk("busy2_stall", stall, 1);
    @(posedge clk); #1 flush = 0; id_valid = 0;
    @(negedge clk);
    chk("flush_stall_low", stall, 0);
    chk("flush_bubble", ex_valid, 0);
    @(posedge clk); #1;
    send(RT, 6'd0, 5'd7, 5'd8, 5'd9, s);
    chk("post_flush_stall", s, 0);
    chk("post_flush_dest", ex_dest, 9);

    // Flush together with a load-use hazard
    send(LW, 6'd0, 5'd1, 5'd6, 5'd0, s);
    id_valid = 1; id_opcode = RT; id_funct = 0; id_rs = 6; id_rt = 1; id_rd = 2; flush = 1;
    @(negedge clk); chk("flu_stall", stall, 1);
    @(posedge clk); #1 flush = 0; id_valid = 0;
    @(negedge clk); chk("flu_no_stall", stall, 0);
    chk("flu_bubble", ex_valid, 0);
    @(posedge clk); #1;
    send(RT, 6'd0, 5'd6, 5'd1, 5'd2, s);
    chk("flu_no_extra", s, 0);

    // Illegal opcode
    send(6'h3f, 6'd0, 5'd1, 5'd2, 5'd3, s);
    chk("ill_pulse", illegal, 1);
    chk("ill_bubble", {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src,
                       ex_branch, ex_alu_op}, 0);
    @(posedge clk); #1;
    chk("ill_one_cycle", illegal, 0);
    c0 = ill_cnt;
    id_valid = 0; id_opcode = 6'h3f;
    repeat (3) @(posedge clk);
    #1 id_opcode = 0;
    chk("ill_invalid_nopulse", ill_cnt - c0, 0);

    // Illegal R-type held under a load-use stall pulses once
    send(LW, 6'd0, 5'd1, 5'd5, 5'd0, s);
    c0 = ill_cnt;
    send(RT, 6'h3f, 5'd5, 5'd0, 5'd0, s);
    chk("ill_stall_cycles", s, 1);
    repeat (2) @(posedge clk);
    #1 chk("ill_once", ill_cnt - c0, 1);

    // Asynchronous reset while BUSY with a valid MUL in ID/EX
    send(RT, 6'd2, 5'd1, 5'd2, 5'd3, s);
    chk("pre_reset_valid", ex_valid, 1);
    #3 reset = 1;
    #1;
    chk("async_reset_out", {illegal, ex_valid, ex_reg_dst, ex_reg_write, ex_alu_op, ex_funct,
                            ex_rs, ex_rt, ex_dest}, 0);
    chk("async_reset_stall", stall, 0);
    @(negedge clk); #2 reset = 0;
    send(SW, 6'd0, 5'd1, 5'd2, 5'd0, s);
    chk("sw_stall", s, 0);
    chk("sw_fields", {ex_valid, ex_mem_write, ex_alu_src, ex_reg_write}, 4'b1110);

    repeat (2) @(posedge clk);
    #1 chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_ctrl_unit.md
Name: pipelined_ctrl_unit

Overview:
- Parametrised successor to the decode-stage control unit.
- Decodes the IF/ID instruction fields into a control bundle and registers it into the ID/EX pipeline register.
- Detects load-use hazards, inserts bubbles, honours branch flushes, and holds the pipeline for a multi-cycle MUL.
- Sits between the IF/ID register and the execute stage. Drives the stall line back to fetch.

Parameters:
- REG_ADDR_W, 5, register-specifier width (rs/rt/rd).
- MUL_LATENCY, 3, extra stall cycles after a MUL issues into ID/EX (0 = single-cycle MUL, no busy state).
- ALU_OP_W, 2, width of the alu_op field.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- id_valid  in  1  IF/ID holds a real instruction.
- id_opcode  in  6  instruction[31:26].
- id_funct  in  6  instruction[5:0].
- id_rs  in  REG_ADDR_W  source register 1.
- id_rt  in  REG_ADDR_W  source register 2 / load destination.
- id_rd  in  REG_ADDR_W  R-type destination.
- flush  in  1  branch taken in EX; kill the instruction in ID.
- stall  out  1  combinational; hold PC and IF/ID this cycle.
- illegal  out  1  registered one-cycle pulse when an unknown opcode/funct is decoded.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write  out  1 each  registered control bits.
- ex_alu_op  out  ALU_OP_W  00 add, 01 subtract/compare, 10 use funct.
- ex_funct  out  6  registered funct.
- ex_rs, ex_rt, ex_dest  out  REG_ADDR_W each  registered specifiers; ex_dest = rd if reg_dst else rt.

Behaviour:
- Reset, asynchronous and immediate:
  - All ex_* outputs and illegal go to 0.
  - The state machine goes to IDLE and the MUL counter to 0.
  - stall = 0 while reset is high.
- Decode (combinational):
  - RTYPE 000000, with funct ADD 000000, SUB 000001 or MUL 000010: reg_dst=1, reg_write=1, alu_op=10.
  - LW 100011: alu_src, mem_read, mem_to_reg and reg_write all 1; alu_op=00.
  - SW 101011: alu_src=1, mem_write=1; alu_op=00.
  - BEQ 000100: branch=1; alu_op=01.
  - ADDI 001000: alu_src=1, reg_write=1; alu_op=00.
  - Any other opcode, or an R-type with any other funct, is illegal.
  - Every control bit not listed above is 0 (no X).
- Bubble definition: all control bits 0, ex_valid=0, all specifier fields 0.
- rt-used: the instruction reads rt. True for RTYPE, SW and BEQ.
- Load-use hazard (lu):
  - Condition: ex_valid & ex_mem_read & ex_rt != 0 & id_valid & (ex_rt == id_rs | (rt-used & ex_rt == id_rt)).
  - Response: stall=1 and a bubble enters ID/EX. Exactly one bubble per load.
- State machine:
  - IDLE -> BUSY when a valid MUL is written into ID/EX and MUL_LATENCY > 0. The counter loads MUL_LATENCY.
  - While BUSY: stall=1, bubbles enter ID/EX, the counter decrements each cycle. The counter reaching 1 returns the machine to IDLE on that edge.
  - A MUL issued at edge t gives stall high for cycles t+1 .. t+MUL_LATENCY.
- stall = lu | BUSY.
- Update priority at each clock edge, highest first:
  1. flush: a bubble enters ID/EX, the machine goes to IDLE, the counter is cleared, stall drops the next cycle.
  2. stall: a bubble enters ID/EX.
  3. id_valid = 0 or illegal: a bubble enters ID/EX. illegal pulses for one cycle only when id_valid = 1 and no flush.
  4. Otherwise the decoded bundle plus specifiers are written and ex_valid = 1.
- Simultaneous events:
  - flush together with lu: the flush wins and no extra bubble follows.
  - An illegal instruction held under stall pulses illegal only once, on the cycle it is finally consumed.
- $zero rule: a load into register 0 never triggers lu.

Decomposition:
- Package ctrl_pkg holds:
  - the opcode constants and funct constants;
  - the ALU_OP constants;
  - a packed struct ctrl_t of the seven control bits plus alu_op;
  - the CTRL_BUBBLE constant.
- One combinational sub-module, ctrl_decode: opcode and funct in; ctrl_t, rt_used, is_mul and illegal out.
- Hazard logic, the FSM and the ID/EX register stay in the top module.

Test Plan:
- Issue LW rt=5, then ADD rs=5 rt=2 rd=7 back-to-back -> stall=1 for exactly 1 cycle, one bubble (ex_valid=0), then ADD with ex_dest=7 and ex_alu_op=10.
- LW rt=0 followed by ADD rs=0 -> stall never asserts, no bubble.
- MUL funct=000010 with MUL_LATENCY=3 -> stall high for exactly 3 cycles after issue, 3 bubbles, next instruction issued on the 4th cycle. Repeat with MUL_LATENCY=0 -> no stall.
- MUL issued, flush asserted on the 2nd busy cycle -> stall low from the next cycle, ex_valid=0 for one cycle, FSM back in IDLE.
- Opcode 111111 with id_valid=1 -> illegal pulses 1 cycle, ex_valid=0, all ex control bits 0. Same opcode with id_valid=0 -> no pulse.
- Assert reset mid-BUSY with ex_valid=1 -> all outputs 0 immediately, without waiting for a clock edge. After release, a SW decodes to mem_write=1, alu_src=1, reg_write=0.
